// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, round count, key-schedule round constants and FSM states
package aes_pkg;
  typedef logic [7:0] byte_t;
  typedef byte_t [3:0][3:0] state_t;
  localparam int NR_AES128 = 10;
  localparam byte_t RCON [11] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  typedef enum logic [1:0] {IDLE, EXPAND, SERVE} fsm_t;
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: forward AES S-box ROM; ports in_byte (8b) -> out_byte (8b), combinational
module aes_sbox
  import aes_pkg::*;
(
  input  byte_t in_byte,
  output byte_t out_byte
);
  localparam byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };
  assign out_byte = SBOX[in_byte];
endmodule

// File: rtl/rev_key_schedule.sv
// rev_key_schedule: AES-128 key expansion served last-round-first; ports clk, rst (async low), key_in/load/next_key in, busy/key_valid/round_idx/key_out out
module rev_key_schedule
  import aes_pkg::*;
#(
  parameter int NR = NR_AES128
) (
  input  logic       clk,
  input  logic       rst,
  input  state_t     key_in,
  input  logic       load,
  input  logic       next_key,
  output logic       busy,
  output logic       key_valid,
  output logic [3:0] round_idx,
  output state_t     key_out
);
  if (NR != NR_AES128) begin : g_bad_nr
    $error("rev_key_schedule supports only NR=10");
  end
  fsm_t       state_q, state_d;
  logic [3:0] cnt_q, cnt_d, round_idx_q, round_idx_d;
  logic       busy_q, busy_d, key_valid_q, key_valid_d;
  state_t     key_out_q, key_out_d;
  state_t     key_buf [0:NR_AES128];
  state_t     prev, nxt, wr_data;
  logic       wr_en;
  logic [3:0] wr_idx;
  byte_t      sub [4];
  byte_t      rcon;
  // word w3 lives in column 0; RotWord moves its row-2 byte to the top (row 3)
  for (genvar i = 0; i < 4; i++) begin : g_sub
    aes_sbox u_sbox (.in_byte(prev[(i + 3) % 4][0]), .out_byte(sub[i]));
  end
  always_comb begin
    prev = key_buf[cnt_q - 4'd1];
    rcon = RCON[cnt_q];
    nxt = '0;
    for (int r = 0; r < 4; r++) begin
      nxt[r][3] = prev[r][3] ^ sub[r] ^ (r == 3 ? rcon : 8'h00);
      nxt[r][2] = prev[r][2] ^ nxt[r][3];
      nxt[r][1] = prev[r][1] ^ nxt[r][2];
      nxt[r][0] = prev[r][0] ^ nxt[r][1];
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    busy_d = busy_q;
    key_valid_d = key_valid_q;
    round_idx_d = round_idx_q;
    key_out_d = key_out_q;
    wr_en = 1'b0;
    wr_idx = '0;
    wr_data = key_in;
    unique case (state_q)
      IDLE: if (load) begin
        state_d = EXPAND;
        cnt_d = 4'd1;
        busy_d = 1'b1;
        wr_en = 1'b1;
      end
      EXPAND: begin
        wr_en = 1'b1;
        wr_idx = cnt_q;
        wr_data = nxt;
        cnt_d = cnt_q + 4'd1;
        // final slot bypasses the buffer so the round-10 key appears with key_valid
        if (cnt_q == 4'd10) begin
          state_d = SERVE;
          busy_d = 1'b0;
          key_valid_d = 1'b1;
          round_idx_d = 4'd10;
          key_out_d = nxt;
        end
      end
      SERVE: if (load) begin
        state_d = EXPAND;
        cnt_d = 4'd1;
        busy_d = 1'b1;
        key_valid_d = 1'b0;
        wr_en = 1'b1;
      end else if (next_key) begin
        if (round_idx_q != 4'd0) begin
          round_idx_d = round_idx_q - 4'd1;
          key_out_d = key_buf[round_idx_q - 4'd1];
        end else begin
          state_d = IDLE;
          key_valid_d = 1'b0;
          round_idx_d = 4'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      busy_q <= 1'b0;
      key_valid_q <= 1'b0;
      round_idx_q <= '0;
      key_out_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      key_valid_q <= key_valid_d;
      round_idx_q <= round_idx_d;
      key_out_q <= key_out_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) key_buf[wr_idx] <= wr_data;
  end
  assign busy = busy_q;
  assign key_valid = key_valid_q;
  assign round_idx = round_idx_q;
  assign key_out = key_out_q;
endmodule

// File: tb/tb_rev_key_schedule.sv
// tb_rev_key_schedule: directed FIPS-197 vectors for the reverse-order key schedule
module tb_rev_key_schedule;
  import aes_pkg::*;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  state_t     key_in = '0;
  logic       load = 1'b0;
  logic       next_key = 1'b0;
  logic       busy, key_valid;
  logic [3:0] round_idx;
  state_t     key_out;
  int         n_chk = 0;
  int         n_pass = 0;
  int         n;
  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K1_R1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K3 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K3_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] K0_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  rev_key_schedule dut (
    .clk(clk), .rst(rst), .key_in(key_in), .load(load), .next_key(next_key),
    .busy(busy), .key_valid(key_valid), .round_idx(round_idx), .key_out(key_out)
  );
  always #5 clk = ~clk;
  function automatic state_t to_state(input logic [127:0] h);
    state_t s;
    for (int b = 0; b < 16; b++) s[3 - b % 4][3 - b / 4] = h[127 - 8 * b -: 8];
    return s;
  endfunction
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_load(input logic [127:0] k);
    key_in = to_state(k);
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask
  task automatic pulse_next();
    next_key = 1'b1;
    tick();
    next_key = 1'b0;
  endtask
  task automatic expand_wait(output int cnt);
    cnt = 0;
    while (busy && cnt < 30) begin
      cnt++;
      tick();
    end
  endtask
  initial begin
    #12;
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_valid", 128'(key_valid), 128'd0);
    chk("rst_idx", 128'(round_idx), 128'd0);
    chk("rst_key", key_out, 128'd0);
    rst = 1'b1;
    tick();
    do_load(K1);
    chk("s1_busy_up", 128'(busy), 128'd1);
    expand_wait(n);
    chk("s1_busy_cycles", 128'(n), 128'd10);
    chk("s1_valid", 128'(key_valid), 128'd1);
    chk("s1_idx", 128'(round_idx), 128'd10);
    chk("s1_key10", key_out, to_state(K1_R10));
    for (int i = 0; i < 9; i++) pulse_next();
    chk("s2_idx1", 128'(round_idx), 128'd1);
    chk("s2_key1", key_out, to_state(K1_R1));
    pulse_next();
    chk("s2_idx0", 128'(round_idx), 128'd0);
    chk("s2_key0", key_out, to_state(K1));
    pulse_next();
    chk("s2_valid_off", 128'(key_valid), 128'd0);
    chk("s2_idx_off", 128'(round_idx), 128'd0);
    chk("s2_key_hold", key_out, to_state(K1));
    pulse_next();
    chk("s6_idle_next_valid", 128'(key_valid), 128'd0);
    chk("s6_idle_next_busy", 128'(busy), 128'd0);
    do_load(K1);
    tick();
    key_in = '0;
    load = 1'b1;
    next_key = 1'b1;
    tick();
    load = 1'b0;
    next_key = 1'b0;
    expand_wait(n);
    chk("s6_busy_cycles", 128'(n), 128'd8);
    chk("s6_idx", 128'(round_idx), 128'd10);
    chk("s6_key10", key_out, to_state(K1_R10));
    pulse_next();
    chk("s6_key9_idx", 128'(round_idx), 128'd9);
    do_load(K3);
    chk("s3_valid_off", 128'(key_valid), 128'd0);
    expand_wait(n);
    chk("s3_busy_cycles", 128'(n), 128'd10);
    chk("s3_key10", key_out, to_state(K3_R10));
    for (int i = 0; i < 3; i++) pulse_next();
    chk("s4_idx7", 128'(round_idx), 128'd7);
    key_in = '0;
    load = 1'b1;
    next_key = 1'b1;
    tick();
    load = 1'b0;
    next_key = 1'b0;
    chk("s4_valid_off", 128'(key_valid), 128'd0);
    chk("s4_busy_on", 128'(busy), 128'd1);
    expand_wait(n);
    chk("s4_busy_cycles", 128'(n), 128'd10);
    chk("s4_idx", 128'(round_idx), 128'd10);
    chk("s4_key10", key_out, to_state(K0_R10));
    do_load(K1);
    for (int i = 0; i < 4; i++) tick();
    #2;
    rst = 1'b0;
    #1;
    chk("s5_async_busy", 128'(busy), 128'd0);
    chk("s5_async_valid", 128'(key_valid), 128'd0);
    tick();
    #3;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("s5_quiet_busy", 128'(busy), 128'd0);
    chk("s5_quiet_valid", 128'(key_valid), 128'd0);
    do_load(K1);
    expand_wait(n);
    chk("s5_busy_cycles", 128'(n), 128'd10);
    chk("s5_valid", 128'(key_valid), 128'd1);
    chk("s5_key10", key_out, to_state(K1_R10));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
